serial_ripple_subtractor: RTL and testbench

Bit-serial subtractor that computes diff = a - b - bin over WIDTH clock cycles, one bit per cycle, LSB first, rippling a borrow through a single registered borrow flop. It is the sequential, inverse-operation counterpart of the combinational ripple-carry adder datapath. It is used where area matters more than latency. Operands enter and results leave through valid/ready handshakes.

---
 rtl/serial_ripple_subtractor.sv | 126 ++++++++++++
 tb/tb_serial_ripple_subtractor.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/serial_ripple_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin, one bit per clock, LSB first,
// with the borrow rippling through a single flop between bit positions.
module serial_ripple_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_res;
    logic             r_borrow;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_diff;
    logic             r_bout;
    logic             r_in_ready;
    logic             r_out_valid;
    logic             r_busy;

    // One full-subtractor cell: returns {borrow_out, difference_bit}.
    function automatic logic [1:0] f_sub_bit(input logic x, input logic y, input logic r);
        logic d;
        logic bo;
        d  = x ^ y ^ r;
        bo = (~x & y) | (~(x ^ y) & r);
        return {bo, d};
    endfunction

    logic [1:0]       w_cell;
    logic             w_d;
    logic             w_borrow_next;
    logic [WIDTH-1:0] w_res_next;

    assign w_cell        = f_sub_bit(r_a_sh[0], r_b_sh[0], r_borrow);
    assign w_d           = w_cell[0];
    assign w_borrow_next = w_cell[1];
    assign w_res_next    = {w_d, r_res[WIDTH-1:1]};

    // Control, operand shifters and result register share one state machine.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_a_sh      <= '0;
            r_b_sh      <= '0;
            r_res       <= '0;
            r_borrow    <= 1'b0;
            r_cnt       <= '0;
            r_diff      <= '0;
            r_bout      <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_a_sh     <= a;
                        r_b_sh     <= b;
                        r_borrow   <= bin;
                        r_res      <= '0;
                        r_cnt      <= '0;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= RUN;
                    end
                end
                RUN: begin
                    r_a_sh   <= {1'b0, r_a_sh[WIDTH-1:1]};
                    r_b_sh   <= {1'b0, r_b_sh[WIDTH-1:1]};
                    r_res    <= w_res_next;
                    r_borrow <= w_borrow_next;
                    r_cnt    <= r_cnt + CNT_W'(1);
                    // Last bit: publish the finished word in the same edge.
                    if (r_cnt == LAST_BIT) begin
                        r_diff      <= w_res_next;
                        r_bout      <= w_borrow_next;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign diff      = r_diff;
    assign bout      = r_bout;

endmodule

// File: tb/tb_serial_ripple_subtractor.sv
// Directed and randomized checks of the bit-serial subtractor against an
// arithmetic reference model (integer subtraction modulo 2^W).
module tb_serial_ripple_subtractor;

    localparam int W = 4;
    localparam int MOD = 1 << W;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         bin = 1'b0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] diff;
    logic         bout;
    logic         busy;

    int checks = 0;
    int errors = 0;

    serial_ripple_subtractor #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int ref_diff(input int x, input int y, input int c);
        int d;
        d = x - y - c;
        return ((d % MOD) + MOD) % MOD;
    endfunction

    function automatic int ref_bout(input int x, input int y, input int c);
        return (x < y + c) ? 1 : 0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_in_ready(input string tag);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        check({tag, " in_ready"}, in_ready, 1);
    endtask

    task automatic accept(input int x, input int y, input int c);
        a        = W'(x);
        b        = W'(y);
        bin      = c[0];
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        a        = W'($urandom);
        b        = W'($urandom);
        bin      = 1'($urandom);
    endtask

    task automatic wait_result(input string tag);
        int lat;
        lat = 0;
        while (!out_valid && lat < 3 * W) begin
            check({tag, " busy"}, busy, 1);
            tick();
            lat++;
        end
        check({tag, " latency"}, lat, W);
    endtask

    task automatic run_op(input string tag, input int x, input int y, input int c, input int stall);
        wait_in_ready(tag);
        accept(x, y, c);
        wait_result(tag);
        check({tag, " diff"}, diff, ref_diff(x, y, c));
        check({tag, " bout"}, bout, ref_bout(x, y, c));
        for (int s = 0; s < stall; s++) begin
            tick();
            check({tag, " stall valid"}, out_valid, 1);
            check({tag, " stall diff"}, diff, ref_diff(x, y, c));
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, " valid drop"}, out_valid, 0);
    endtask

    initial begin
        #1 rst = 1'b1;
        #2;
        check("rst in_ready", in_ready, 1);
        check("rst out_valid", out_valid, 0);
        check("rst busy", busy, 0);
        check("rst diff", diff, 0);
        check("rst bout", bout, 0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        run_op("9-3", 9, 3, 0, 0);
        run_op("3-9", 3, 9, 0, 1);
        run_op("5-5", 5, 5, 0, 0);
        run_op("0-0-1", 0, 0, 1, 2);
        run_op("15-15-1", 15, 15, 1, 0);

        // Backpressure with in_valid pulsing while the result is held.
        wait_in_ready("bp");
        accept(9, 3, 0);
        wait_result("bp");
        for (int s = 0; s < 5; s++) begin
            in_valid = s[0];
            a = W'($urandom);
            b = W'($urandom);
            tick();
            check("bp out_valid", out_valid, 1);
            check("bp in_ready", in_ready, 0);
            check("bp diff", diff, 6);
            check("bp bout", bout, 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp release valid", out_valid, 0);
        check("bp release in_ready", in_ready, 1);
        tick();
        check("bp no new op", busy, 0);

        // Reset two cycles into a run abandons it without a clock edge.
        wait_in_ready("rstmid");
        accept(12, 4, 0);
        tick();
        tick();
        check("rstmid busy before", busy, 1);
        rst = 1'b1;
        #1;
        check("rstmid out_valid", out_valid, 0);
        check("rstmid busy", busy, 0);
        check("rstmid diff", diff, 0);
        check("rstmid bout", bout, 0);
        check("rstmid in_ready", in_ready, 1);
        #2 rst = 1'b0;
        tick();
        run_op("15-1-1", 15, 1, 1, 0);

        // Exhaustive sweep with random downstream stalls.
        for (int k = 0; k < 2 * MOD * MOD; k++) begin
            run_op("sweep", k % MOD, (k / MOD) % MOD, k / (MOD * MOD), $urandom_range(0, 2));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
